// File: rtl/seq_div.sv
// seq_div: iterative restoring integer divider (RV64M DIV/DIVU/REM/REMU).
//   Produces one quotient bit per cycle, MSB first. Signed operands are divided as
//   magnitudes, and the signs are applied in a one-cycle FIX state.
//   Divide-by-zero and signed overflow resolve immediately with RISC-V results.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (in_ready only while IDLE)
//   is_signed               1: DIV/REM, 0: DIVU/REMU
//   dividend, divisor       operands, sampled on the accept cycle only
//   kill                    synchronous abort back to IDLE, drops any result
//   out_valid/out_ready     result handshake, result held until consumed
//   quotient, remainder     result registers
module seq_div #(
    parameter int div_size = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_signed,
    input  logic [div_size-1:0] dividend,
    input  logic [div_size-1:0] divisor,
    input  logic                kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [div_size-1:0] quotient,
    output logic [div_size-1:0] remainder
);
    localparam int CW = (div_size > 1) ? $clog2(div_size) : 1;
    localparam logic [div_size-1:0] ONE = {{(div_size-1){1'b0}}, 1'b1};
    localparam logic [div_size-1:0] MIN = {1'b1, {(div_size-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [div_size-1:0] dvd;   // dividend magnitude shifting out, quotient shifting in
    logic [div_size-1:0] dsr;   // divisor magnitude
    logic [div_size-1:0] rem;   // partial remainder, always < dsr between steps
    logic                neg_q;
    logic                neg_r;

    logic [div_size:0]   rem_sh;
    logic [div_size:0]   diff;
    logic                ge;
    logic [div_size-1:0] a_mag, b_mag, q_fix, r_fix;
    logic                unused_diff_msb;

    always_comb begin
        // Trial remainder is one bit wider than the operands so the compare never wraps.
        rem_sh = {rem, dvd[div_size-1]};
        ge     = rem_sh >= {1'b0, dsr};
        diff   = rem_sh - {1'b0, dsr};
        a_mag  = (is_signed && dividend[div_size-1]) ? (~dividend + ONE) : dividend;
        b_mag  = (is_signed && divisor[div_size-1])  ? (~divisor + ONE)  : divisor;
        q_fix  = neg_q ? (~dvd + ONE) : dvd;
        r_fix  = neg_r ? (~rem + ONE) : rem;
    end

    // After a successful subtract the difference is below the divisor, so its MSB is always 0.
    assign unused_diff_msb = diff[div_size];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (kill) begin
            // Result registers intentionally keep stale values; only the handshake is cleared.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        neg_q    <= is_signed & (dividend[div_size-1] ^ divisor[div_size-1]);
                        neg_r    <= is_signed & dividend[div_size-1];
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (is_signed && dividend == MIN && divisor == '1) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dvd   <= a_mag;
                            dsr   <= b_mag;
                            rem   <= '0;
                            cnt   <= CW'(div_size - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= ge ? diff[div_size-1:0] : rem_sh[div_size-1:0];
                    dvd <= {dvd[div_size-2:0], ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div (div_size=8).
//   The driver pushes the model's expected {quotient,remainder} when it issues an op.
//   A negedge monitor pops and compares on every result handshake.
module tb_seq_div;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          is_signed = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          kill = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    int nchk = 0;
    int nerr = 0;
    logic [2*DW-1:0] exp_q[$];

    seq_div #(.div_size(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics in plain integer arithmetic (/ and % truncate toward zero).
    function automatic logic [2*DW-1:0] model(input bit sg, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sa, sb, q, r;
        if (b == '0) return {{DW{1'b1}}, a};
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        if (sg && sa == -(1 << (DW-1)) && sb == -1) return {a, {DW{1'b0}}};
        q = sa / sb;
        r = sa % sb;
        return {q[DW-1:0], r[DW-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every consumed result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {quotient, remainder}, 32'hdead);
            end else begin
                logic [2*DW-1:0] e;
                e = exp_q.pop_front();
                chk("result_qr", {quotient, remainder}, e);
            end
        end
    end

    task automatic do_op(input bit sg, input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        int k, lat;
        logic [DW-1:0] hq, hr;
        k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk("in_ready_before_op", in_ready, 1);
        lat = (b == '0 || (sg && a == 8'h80 && b == 8'hFF)) ? 1 : DW + 2;
        exp_q.push_back(model(sg, a, b));
        in_valid = 1'b1; is_signed = sg; dividend = a; divisor = b;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        // Operands are don't-care after the accept edge; scramble them.
        in_valid = 1'b0; is_signed = 1'($urandom); dividend = DW'($urandom); divisor = DW'($urandom);
        k = 1;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("latency", k, lat);
        chk("in_ready_low_with_out_valid", in_ready, 0);
        if (hold > 0) begin
            hq = quotient; hr = remainder;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_out_valid_held", out_valid, 1);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_q_stable", quotient, hq);
                chk("bp_r_stable", remainder, hr);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("in_ready_after_consume", in_ready, 1);
        chk("out_valid_after_consume", out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        int k;
        // Reset state
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases
        do_op(0, 8'd100, 8'd7, 0);
        do_op(1, 8'hF9, 8'h02, 0);
        do_op(1, 8'h07, 8'hFE, 0);
        do_op(0, 8'h05, 8'h00, 0);
        do_op(1, 8'h05, 8'h00, 0);
        do_op(1, 8'h80, 8'hFF, 0);
        do_op(0, 8'h80, 8'hFF, 0);
        do_op(0, 8'd100, 8'd7, 5);

        // kill at cycle 4 of CALC
        in_valid = 1'b1; is_signed = 1'b0; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        chk("kill_in_ready", in_ready, 1);
        chk("kill_out_valid", out_valid, 0);
        expect_quiet("kill_no_result", 15);

        // kill outranks accept in the same cycle
        in_valid = 1'b1; kill = 1'b1; dividend = 8'd9; divisor = 8'd0;
        @(posedge clk); #1 in_valid = 1'b0; kill = 1'b0;
        chk("kill_accept_in_ready", in_ready, 1);
        expect_quiet("kill_accept_dropped", 12);

        // rst_n pulse mid-operation
        in_valid = 1'b1; is_signed = 1'b0; dividend = 8'd50; divisor = 8'd3;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        expect_quiet("midrst_no_result", 15);
        do_op(0, 8'd200, 8'd3, 0);

        // Random sweep with special-case bias and random back-pressure
        for (int i = 0; i < 60; i++) begin
            int pick;
            logic [DW-1:0] a, b;
            bit sg;
            pick = $urandom_range(0, 7);
            sg = 1'($urandom);
            a = DW'($urandom);
            b = DW'($urandom);
            if (pick == 0) b = '0;
            else if (pick == 1) begin a = 8'h80; b = 8'hFF; end
            else if (pick == 2) b = 8'h01;
            do_op(sg, a, b, $urandom_range(0, 2));
        end

        k = 0;
        while (exp_q.size() > 0 && k < 50) begin @(posedge clk); k++; end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
